// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_ADDRESS_WIDTH = 5;
    localparam int DEFAULT_NUM_READ      = 2;

    // Architectural register indices with fixed roles.
    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register. A producer issue sets its destination bit and a
// register write clears it. If both hit the same register in one cycle, the set
// wins so that the newly issued producer stays tracked. Register 0 never pends.
// The output is the next-state vector: it already includes this cycle's set and
// clear, which lets the read ports register busy in step with their data.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_en,
    input  logic [ADDRESS_WIDTH-1:0]      set_idx,
    input  logic                          clr_en,
    input  logic [ADDRESS_WIDTH-1:0]      clr_idx,
    output logic [(2**ADDRESS_WIDTH)-1:0] pending
);

    logic [(2**ADDRESS_WIDTH)-1:0] pending_q;

    // Next-state pending vector: clear first, then set, so the set wins on a collision.
    always_comb begin
        pending = pending_q;
        if (clr_en) begin
            pending[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending[set_idx] = 1'b1;
        end
        pending[REG_ZERO] = 1'b0;
    end

    // Pending-bit state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with a per-register pending scoreboard. Reads are registered,
// with one cycle of latency, and a write in the same cycle is forwarded to them.
// Each read port also reports whether its register is still waiting for a
// producer. Register 0 always reads as zero, and a0 is a registered copy of x10.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int NUM_READ      = DEFAULT_NUM_READ
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rs_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_READ-1:0]               busy,
    input  logic                              we,
    input  logic [ADDRESS_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]             wd,
    input  logic                              issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]          issue_rd,
    output logic [DATA_WIDTH-1:0]             a0
);

    localparam int NUM_REGS = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(REG_ZERO);
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX   = ADDRESS_WIDTH'(REG_A0);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_next;
    logic                  wr_en;

    assign wr_en = we && (wa != ZERO_IDX);

    regfile_scoreboard #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_valid),
        .set_idx (issue_rd),
        .clr_en  (we),
        .clr_idx (wa),
        .pending (pending_next)
    );

    // Register storage. x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // a0 mirror of x10; a write to x10 in the same cycle is forwarded to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a0 <= '0;
        end else if (we && wa == A0_IDX) begin
            a0 <= wd;
        end else begin
            a0 <= regs[A0_IDX];
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data_q;
        logic                     busy_q;

        assign addr = rs_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        // Registered read with write forwarding; busy comes from the next-state pending bit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else begin
                if (addr == ZERO_IDX) begin
                    data_q <= '0;
                end else if (we && wa == addr) begin
                    data_q <= wd;
                end else begin
                    data_q <= regs[addr];
                end
                busy_q <= pending_next[addr];
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign busy[i] = busy_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb with four read ports. A reference model holds the
// register contents and pending flags as plain arrays, and a compare process
// checks every output against it on each falling edge. Directed steps add
// literal expectations at known points, followed by a stretch of random traffic.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR*AW-1:0] rs_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    busy;
    logic             we = 1'b0;
    logic [AW-1:0]    wa = '0;
    logic [DW-1:0]    wd = '0;
    logic             issue_valid = 1'b0;
    logic [AW-1:0]    issue_rd = '0;
    logic [DW-1:0]    a0;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb #(
        .DATA_WIDTH(DW),
        .ADDRESS_WIDTH(AW),
        .NUM_READ(NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .we          (we),
        .wa          (wa),
        .wd          (wd),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .a0          (a0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: architectural contents, pending flags and expected outputs.
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [31:0] m_np;
    logic [31:0] e_rd [NR];
    logic [NR-1:0] e_busy;
    logic [31:0] e_a0;
    logic [AW-1:0] m_a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
            m_pend = 32'h0;
            for (int p = 0; p < NR; p++) e_rd[p] = 32'h0;
            e_busy = '0;
            e_a0 = 32'h0;
        end else begin
            m_np = m_pend;
            if (we) m_np[wa] = 1'b0;
            if (issue_valid && issue_rd != 0) m_np[issue_rd] = 1'b1;
            for (int p = 0; p < NR; p++) begin
                m_a = rs_addr[p*AW +: AW];
                if (m_a == 0)                 e_rd[p] = 32'h0;
                else if (we && wa == m_a)     e_rd[p] = wd;
                else                          e_rd[p] = m_regs[m_a];
                e_busy[p] = m_np[m_a];
            end
            e_a0 = (we && wa == 5'd10) ? wd : m_regs[10];
            if (we && wa != 0) m_regs[wa] = wd;
            m_pend = m_np;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("model_rd%0d", p), rd_data[p*DW +: DW], e_rd[p]);
            chk($sformatf("model_busy%0d", p), 32'(busy[p]), 32'(e_busy[p]));
        end
        chk("model_a0", a0, e_a0);
    end

    // Apply one cycle of inputs and return after the following falling edge.
    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic iv, input logic [AW-1:0] ir,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [AW-1:0] r2, input logic [AW-1:0] r3);
        we = w; wa = a; wd = d;
        issue_valid = iv; issue_rd = ir;
        rs_addr = {r3, r2, r1, r0};
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_rd0", rd_data[0 +: DW], 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_a0", a0, 32'h0);
        rst = 1'b0;

        // Write then read back with one-cycle latency.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 5, 0, 0, 0);
        chk("wr_rd_x5", rd_data[0 +: DW], 32'hDEADBEEF);

        // Same-cycle bypass on port 1.
        drive(1, 7, 32'h1234, 0, 0, 0, 7, 0, 0);
        chk("bypass_x7", rd_data[DW +: DW], 32'h1234);

        // x0 is hardwired to zero and never pends.
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
        for (int p = 0; p < NR; p++)
            chk($sformatf("x0_rd%0d", p), rd_data[p*DW +: DW], 32'h0);
        chk("x0_busy_issue", 32'(busy), 32'h0);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("x0_busy_after", 32'(busy), 32'h0);

        // Scoreboard set, set-wins collision, clear.
        drive(0, 0, 32'h0, 1, 3, 3, 0, 0, 0);
        chk("x3_busy_set", 32'(busy[0]), 32'h1);
        drive(1, 3, 32'h33, 1, 3, 3, 0, 0, 0);
        chk("x3_busy_collide", 32'(busy[0]), 32'h1);
        chk("x3_rd_collide", rd_data[0 +: DW], 32'h33);
        drive(1, 3, 32'h44, 0, 0, 3, 0, 0, 0);
        chk("x3_busy_clear", 32'(busy[0]), 32'h0);
        chk("x3_rd_clear", rd_data[0 +: DW], 32'h44);
        drive(0, 0, 32'h0, 0, 0, 3, 3, 0, 0);
        chk("x3_rd_port1", rd_data[DW +: DW], 32'h44);

        // a0 mirror, then asynchronous reset in mid-cycle.
        drive(1, 10, 32'h55, 1, 12, 10, 0, 0, 0);
        chk("a0_bypass", a0, 32'h55);
        chk("x10_rd_bypass", rd_data[0 +: DW], 32'h55);
        drive(0, 0, 32'h0, 0, 0, 10, 12, 0, 0);
        chk("a0_hold", a0, 32'h55);
        chk("x12_busy", 32'(busy[1]), 32'h1);
        we = 1'b1; wa = 5'd10; wd = 32'h99;
        issue_valid = 1'b1; issue_rd = 5'd4;
        #2 rst = 1'b1;
        #1;
        chk("rst_a0", a0, 32'h0);
        for (int p = 0; p < NR; p++)
            chk($sformatf("rst_rd%0d", p), rd_data[p*DW +: DW], 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 10, 4, 12, 0);
        chk("post_rst_x10", rd_data[0 +: DW], 32'h0);
        chk("post_rst_a0", a0, 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);

        // All four ports read the same register.
        drive(1, 9, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 9, 9, 9, 9);
        for (int p = 0; p < NR; p++)
            chk($sformatf("x9_rd%0d", p), rd_data[p*DW +: DW], 32'hA5A5A5A5);

        // Random traffic on a narrow address range, checked by the model.
        for (int n = 0; n < 80; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)),
                  5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                  5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
        end

        drive(0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
